// File: rtl/clock_divider_multi.sv
// Multi-channel clock-enable divider. Each channel counts 0..D at its active
// divisor D and emits a registered one-cycle terminal-count strobe (tc) and a
// div_out that is either a 50% toggle or a copy of tc. New divisor/mode
// settings are staged in a per-channel shadow and only applied at a safe
// point: the channel's terminal count, while it is disabled, or on
// sync_restart. That way a running period is never cut short.
module clock_divider_multi #(
    parameter int          NUM_CH       = 4,
    parameter int          WIDTH        = 24,
    parameter int unsigned DEFAULT_DIV  = 1,
    parameter bit          DEFAULT_MODE = 1'b0,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tc
);

    // Configuration handshake: a write transfers on a clk edge where
    // cfg_valid && cfg_ready. cfg_ready is low only while the addressed
    // channel already holds an unapplied shadow; the master must keep
    // cfg_valid and the payload stable until it transfers. Writes to a
    // channel index >= NUM_CH are always ready and are dropped.

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    logic [NUM_CH-1:0] pending;

    // Ready reflects the pending flag of whichever channel is addressed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cfg_ch == CH_W'(k)) begin
                cfg_ready = ~pending[k];
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] act_div;
        logic [WIDTH-1:0] shd_div;
        logic             act_mode;
        logic             shd_mode;
        logic             pend;
        logic             div_q;
        logic             tc_q;
        logic             at_tc;
        logic             apply;
        logic             accept;

        // Decode this cycle's terminal count, shadow apply and write accept.
        // apply uses the pending flag as it stands before this edge, so a
        // write accepted on a TC cycle waits for the following TC.
        always_comb begin
            at_tc  = en[i] && (cnt == act_div);
            apply  = pend && (sync_restart || !en[i] || at_tc);
            accept = cfg_valid && !pend && (cfg_ch == CH_W'(i));
        end

        // Shadow/active configuration and the counter with its registered outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt      <= '0;
                act_div  <= RST_DIV;
                shd_div  <= RST_DIV;
                act_mode <= DEFAULT_MODE;
                shd_mode <= DEFAULT_MODE;
                pend     <= 1'b0;
                div_q    <= 1'b0;
                tc_q     <= 1'b0;
            end else begin
                // accept needs !pend and apply needs pend: never both at once.
                if (accept) begin
                    shd_div  <= cfg_div;
                    shd_mode <= cfg_mode;
                    pend     <= 1'b1;
                end else if (apply) begin
                    act_div  <= shd_div;
                    act_mode <= shd_mode;
                    pend     <= 1'b0;
                end

                if (sync_restart || !en[i]) begin
                    cnt   <= '0;
                    div_q <= 1'b0;
                    tc_q  <= 1'b0;
                end else if (at_tc) begin
                    // The old period has completed; a mode switch starts clean at 0.
                    cnt  <= '0;
                    tc_q <= 1'b1;
                    if (apply && (shd_mode != act_mode)) begin
                        div_q <= 1'b0;
                    end else if (act_mode) begin
                        div_q <= 1'b1;
                    end else begin
                        div_q <= ~div_q;
                    end
                end else begin
                    cnt  <= cnt + WIDTH'(1);
                    tc_q <= 1'b0;
                    if (act_mode) begin
                        div_q <= 1'b0;
                    end
                end
            end
        end

        assign pending[i] = pend;
        assign div_out[i] = div_q;
        assign tc[i]      = tc_q;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi. A timestamp-based reference
// model (period start cycle, active/shadow settings per channel) predicts
// cfg_ready before every edge and div_out/tc after it; scenario tasks add
// targeted checks on latencies and pulse counts.
module tb_clock_divider_multi;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 24;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync_restart;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [WIDTH-1:0]  cfg_div;
    logic              cfg_mode;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tc;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_div   [NUM_CH];
    bit m_mode  [NUM_CH];
    bit m_pend  [NUM_CH];
    int m_sdiv  [NUM_CH];
    bit m_smode [NUM_CH];
    int m_start [NUM_CH];
    bit m_out   [NUM_CH];
    bit m_tc    [NUM_CH];
    int cyc = 0;

    clock_divider_multi #(
        .NUM_CH(NUM_CH),
        .WIDTH(WIDTH),
        .DEFAULT_DIV(1),
        .DEFAULT_MODE(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .sync_restart(sync_restart),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .cfg_mode(cfg_mode),
        .div_out(div_out),
        .tc(tc)
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_div[c]   = 1;
            m_mode[c]  = 1'b0;
            m_pend[c]  = 1'b0;
            m_sdiv[c]  = 1;
            m_smode[c] = 1'b0;
            m_start[c] = cyc;
            m_out[c]   = 1'b0;
            m_tc[c]    = 1'b0;
        end
    endtask

    // Advance the model by one clk cycle using the inputs currently driven.
    // A period starts at m_start; its terminal count is the cycle that lies
    // exactly m_div cycles after the start.
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            bit at_tc;
            bit apply;
            bit acc;
            at_tc = en[c] && ((cyc - m_start[c]) == m_div[c]);
            apply = m_pend[c] && (sync_restart || !en[c] || at_tc);
            acc   = cfg_valid && !m_pend[c] && (int'(cfg_ch) == c);
            if (sync_restart || !en[c]) begin
                m_out[c]   = 1'b0;
                m_tc[c]    = 1'b0;
                m_start[c] = cyc + 1;
            end else if (at_tc) begin
                m_tc[c] = 1'b1;
                if (apply && (m_smode[c] != m_mode[c])) m_out[c] = 1'b0;
                else if (m_mode[c]) m_out[c] = 1'b1;
                else m_out[c] = ~m_out[c];
                m_start[c] = cyc + 1;
            end else begin
                m_tc[c] = 1'b0;
                if (m_mode[c]) m_out[c] = 1'b0;
            end
            if (apply) begin
                m_div[c]  = m_sdiv[c];
                m_mode[c] = m_smode[c];
                m_pend[c] = 1'b0;
            end
            if (acc) begin
                m_sdiv[c]  = int'(cfg_div);
                m_smode[c] = cfg_mode;
                m_pend[c]  = 1'b1;
            end
        end
        cyc++;
    endtask

    // One clk cycle: check cfg_ready, step the model, check registered outputs.
    task automatic cycle();
        logic              exp_ready;
        logic [NUM_CH-1:0] exp_out;
        logic [NUM_CH-1:0] exp_tc;
        #1;
        exp_ready = !m_pend[cfg_ch];
        checks++;
        if (cfg_ready !== exp_ready) begin
            errors++;
            $display("FAIL cfg_ready cyc=%0d ch=%0d got %b want %b", cyc, cfg_ch, cfg_ready, exp_ready);
        end
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_out[c] = m_out[c];
            exp_tc[c]  = m_tc[c];
        end
        checks++;
        if (div_out !== exp_out) begin
            errors++;
            $display("FAIL div_out cyc=%0d got %b want %b", cyc, div_out, exp_out);
        end
        checks++;
        if (tc !== exp_tc) begin
            errors++;
            $display("FAIL tc cyc=%0d got %b want %b", cyc, tc, exp_tc);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Hold a write request until it transfers (bounded).
    task automatic cfg_write(input int ch, input int d, input bit mode);
        int budget;
        bit done;
        budget    = 0;
        done      = 1'b0;
        cfg_valid = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_div   = WIDTH'(d);
        cfg_mode  = mode;
        while (!done && budget < 100) begin
            done = !m_pend[ch];
            cycle();
            budget++;
        end
        cfg_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL cfg_write_timeout ch=%0d got stalled want accepted", ch);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        en           = '1;
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_div      = '0;
        cfg_mode     = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (div_out !== '0) begin errors++; $display("FAIL reset_div_out got %b want 0", div_out); end
        checks++;
        if (tc !== '0) begin errors++; $display("FAIL reset_tc got %b want 0", tc); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_default_toggle();
        int tcs;
        int flips;
        logic prev;
        tcs   = 0;
        flips = 0;
        prev  = div_out[3];
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (tc[3]) tcs++;
            if (div_out[3] !== prev) flips++;
            prev = div_out[3];
        end
        checks++;
        if (tcs != 4) begin errors++; $display("FAIL default_tc_count got %0d want 4", tcs); end
        checks++;
        if (flips != 4) begin errors++; $display("FAIL default_toggle_count got %0d want 4", flips); end
        run(4);
    endtask

    task automatic test_pulse_write();
        int pulses;
        run($urandom_range(0, 3));
        cfg_write(2, 4, 1'b1);
        run(25);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (div_out[2]) pulses++;
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL pulse_count ch2 got %0d want 2", pulses); end
    endtask

    task automatic test_write_stall();
        cfg_write(2, int'($urandom_range(3, 6)), 1'b0);
        cfg_ch = 2'd2;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin errors++; $display("FAIL stall_ready ch2 got %b want 0", cfg_ready); end
        cfg_valid = 1'b1;
        cfg_div   = WIDTH'(7);
        cfg_mode  = 1'b1;
        cycle();
        cfg_ch = 2'd1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL other_ch_ready ch1 got %b want 1", cfg_ready); end
        cfg_write(1, int'($urandom_range(1, 4)), 1'b0);
        cfg_write(2, 7, 1'b1);
        run(20);
    endtask

    task automatic test_enable();
        int n;
        en[0] = 1'b0;
        cycle();
        cfg_write(0, 3, 1'b0);
        run(5);
        checks++;
        if (div_out[0] !== 1'b0) begin errors++; $display("FAIL disabled_out ch0 got %b want 0", div_out[0]); end
        en[0] = 1'b1;
        n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (div_out[0] === 1'b1) break;
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL first_toggle_latency ch0 got %0d want 4", n); end
        run(10);
    endtask

    task automatic test_sync_restart();
        int first [NUM_CH];
        int want  [NUM_CH];
        want = '{3, 6, 10, 7};
        cfg_write(0, 2, 1'($urandom_range(0, 1)));
        cfg_write(1, 5, 1'($urandom_range(0, 1)));
        cfg_write(2, 9, 1'($urandom_range(0, 1)));
        cfg_write(3, 20, 1'b0);
        run(30 + $urandom_range(0, 7));
        cfg_write(3, 6, 1'b0);
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        checks++;
        if (tc !== '0) begin errors++; $display("FAIL restart_tc got %b want 0", tc); end
        for (int c = 0; c < NUM_CH; c++) first[c] = 0;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            for (int c = 0; c < NUM_CH; c++) begin
                if (first[c] == 0 && tc[c] === 1'b1) first[c] = k;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (first[c] != want[c]) begin
                errors++;
                $display("FAIL restart_first_tc ch%0d got %0d want %0d", c, first[c], want[c]);
            end
        end
    endtask

    task automatic test_div_zero();
        cfg_write(1, 0, 1'b1);
        cfg_write(0, 0, 1'b0);
        run(15);
        for (int k = 0; k < 5; k++) begin
            cycle();
            checks++;
            if (div_out[1] !== 1'b1) begin errors++; $display("FAIL d0_pulse_high ch1 got %b want 1", div_out[1]); end
        end
    endtask

    task automatic test_reset_mid();
        cfg_write(2, 15, 1'b0);
        cfg_ch = 2'd2;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (div_out !== '0) begin errors++; $display("FAIL async_reset_div_out got %b want 0", div_out); end
        checks++;
        if (tc !== '0) begin errors++; $display("FAIL async_reset_tc got %b want 0", tc); end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready ch2 got %b want 1", cfg_ready); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run(12);
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, NUM_CH - 1);
                en[k] = ~en[k];
            end
            sync_restart = ($urandom_range(0, 49) == 0);
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = CH_W'($urandom_range(0, NUM_CH - 1));
            cfg_div      = WIDTH'($urandom_range(0, 10));
            cfg_mode     = 1'($urandom_range(0, 1));
            cycle();
        end
        sync_restart = 1'b0;
        cfg_valid    = 1'b0;
        en           = '1;
        run(30);
    endtask

    initial begin
        test_reset();
        test_default_toggle();
        test_pulse_write();
        test_write_stall();
        test_enable();
        test_sync_restart();
        test_div_zero();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
